batrider_gfx_bank_arbiter: RTL and testbench

//  Shares one SDRAM read bank between four 32-bit graphics fetchers:
//    - requester 0: sprites
//    - requesters 1-3: scroll layers 0-2

---
 rtl/batrider_gfx_bank_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_batrider_gfx_bank_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/batrider_gfx_bank_arbiter.sv
// Four-requester arbiter for one shared SDRAM read bank. Each 32-bit fetch
// becomes a two-beat 16-bit burst, and each requester has a one-entry tag/data cache.
module batrider_gfx_bank_arbiter #(
  parameter bit          RR_EN   = 1'b1,
  parameter logic [21:0] OFFSET0 = 22'd0,
  parameter logic [21:0] OFFSET1 = 22'd0,
  parameter logic [21:0] OFFSET2 = 22'd0,
  parameter logic [21:0] OFFSET3 = 22'd0
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [3:0]  REQ_CS,
  input  logic [21:0] REQ_ADDR0,
  input  logic [21:0] REQ_ADDR1,
  input  logic [21:0] REQ_ADDR2,
  input  logic [21:0] REQ_ADDR3,
  output logic [3:0]  REQ_OK,
  output logic [31:0] REQ_DOUT0,
  output logic [31:0] REQ_DOUT1,
  output logic [31:0] REQ_DOUT2,
  output logic [31:0] REQ_DOUT3,
  output logic [21:0] BA_ADDR,
  output logic        BA_RD,
  input  logic        BA_ACK,
  input  logic        BA_DST,
  input  logic        BA_DOK,
  input  logic        BA_RDY,
  input  logic [15:0] DATA_READ,
  output logic        BUSY,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [21:0] OFFS [4] = '{OFFSET0, OFFSET1, OFFSET2, OFFSET3};

  // Handshake: BA_RD rises with BA_ADDR valid and both hold until the cycle
  // BA_ACK is seen high (that cycle included); beats are accepted only after ACK.
  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_q, last_d;
  logic [21:0] addr_q, addr_d;
  logic [21:0] ba_addr_q, ba_addr_d;
  logic        ba_rd_q, ba_rd_d;
  logic [1:0]  beat_q, beat_d;
  logic [3:0]  valid_q, valid_d;
  logic [21:0] tag_q [4];
  logic [21:0] tag_d [4];
  logic [31:0] dout_q [4];
  logic [31:0] dout_d [4];

  logic [21:0] req_addr [4];
  logic [3:0]  hit, miss;
  logic [1:0]  pick, scan_idx;
  logic        found;
  logic        dst_unused;

  assign req_addr[0] = REQ_ADDR0;
  assign req_addr[1] = REQ_ADDR1;
  assign req_addr[2] = REQ_ADDR2;
  assign req_addr[3] = REQ_ADDR3;
  assign dst_unused  = BA_DST;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      hit[n] = valid_q[n] && (tag_q[n] == req_addr[n]);
    end
  end

  assign miss   = REQ_CS & ~hit;
  assign REQ_OK = REQ_CS & hit;

  // Round-robin scan starts one past the last granted requester.
  always_comb begin
    pick     = 2'd0;
    found    = 1'b0;
    scan_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      scan_idx = RR_EN ? 2'(last_q + 2'(i + 1)) : 2'(i);
      if (!found && miss[scan_idx]) begin
        pick  = scan_idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    addr_d    = addr_q;
    ba_addr_d = ba_addr_q;
    ba_rd_d   = ba_rd_q;
    beat_d    = beat_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    dout_d    = dout_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d       = pick;
          addr_d        = req_addr[pick];
          ba_addr_d     = req_addr[pick] + OFFS[pick];
          ba_rd_d       = 1'b1;
          valid_d[pick] = 1'b0;
          beat_d        = 2'd0;
          state_d       = S_REQ;
        end
      end
      S_REQ: begin
        if (BA_ACK) begin
          ba_rd_d = 1'b0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (BA_DOK) begin
          if (beat_q == 2'd0) begin
            dout_d[grant_q][15:0] = DATA_READ;
            beat_d                = 2'd1;
          end else if (beat_q == 2'd1) begin
            dout_d[grant_q][31:16] = DATA_READ;
            beat_d                 = 2'd2;
          end
        end
        if (BA_RDY) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        tag_d[grant_q]   = addr_q;
        valid_d[grant_q] = 1'b1;
        last_d           = grant_q;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'd0;
      last_q    <= 2'd0;
      addr_q    <= 22'd0;
      ba_addr_q <= 22'd0;
      ba_rd_q   <= 1'b0;
      beat_q    <= 2'd0;
      valid_q   <= 4'd0;
      for (int n = 0; n < 4; n++) begin
        tag_q[n]  <= 22'd0;
        dout_q[n] <= 32'd0;
      end
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      ba_addr_q <= ba_addr_d;
      ba_rd_q   <= ba_rd_d;
      beat_q    <= beat_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      dout_q    <= dout_d;
    end
  end

  assign REQ_DOUT0 = dout_q[0];
  assign REQ_DOUT1 = dout_q[1];
  assign REQ_DOUT2 = dout_q[2];
  assign REQ_DOUT3 = dout_q[3];
  assign BA_ADDR   = ba_addr_q;
  assign BA_RD     = ba_rd_q;
  assign BUSY      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_batrider_gfx_bank_arbiter.sv
// Directed bench for batrider_gfx_bank_arbiter: a round-robin instance and a
// fixed-priority instance share all inputs and are checked in lockstep.
module tb_batrider_gfx_bank_arbiter;

  logic        CLK;
  logic        RESET_N;
  logic [3:0]  REQ_CS;
  logic [21:0] REQ_ADDR0, REQ_ADDR1, REQ_ADDR2, REQ_ADDR3;
  logic        BA_ACK, BA_DST, BA_DOK, BA_RDY;
  logic [15:0] DATA_READ;

  logic [3:0]  REQ_OK;
  logic [31:0] REQ_DOUT0, REQ_DOUT1, REQ_DOUT2, REQ_DOUT3;
  logic [21:0] BA_ADDR;
  logic        BA_RD, BUSY;
  logic [1:0]  dbg_state;

  logic [3:0]  fp_ok;
  logic [31:0] fp_dout0, fp_dout1, fp_dout2, fp_dout3;
  logic [21:0] fp_ba_addr;
  logic        fp_ba_rd, fp_busy;
  logic [1:0]  fp_dbg_state;

  int total = 0;
  int bad   = 0;
  int beat_mon = 0;

  batrider_gfx_bank_arbiter #(
    .RR_EN(1'b1), .OFFSET0(22'h200000), .OFFSET1(22'h000010),
    .OFFSET2(22'h000020), .OFFSET3(22'h3FFFF0)
  ) u_rr (
    .CLK(CLK), .RESET_N(RESET_N), .REQ_CS(REQ_CS),
    .REQ_ADDR0(REQ_ADDR0), .REQ_ADDR1(REQ_ADDR1), .REQ_ADDR2(REQ_ADDR2), .REQ_ADDR3(REQ_ADDR3),
    .REQ_OK(REQ_OK),
    .REQ_DOUT0(REQ_DOUT0), .REQ_DOUT1(REQ_DOUT1), .REQ_DOUT2(REQ_DOUT2), .REQ_DOUT3(REQ_DOUT3),
    .BA_ADDR(BA_ADDR), .BA_RD(BA_RD), .BA_ACK(BA_ACK), .BA_DST(BA_DST),
    .BA_DOK(BA_DOK), .BA_RDY(BA_RDY), .DATA_READ(DATA_READ),
    .BUSY(BUSY), .dbg_state(dbg_state)
  );

  batrider_gfx_bank_arbiter #(
    .RR_EN(1'b0), .OFFSET0(22'h200000), .OFFSET1(22'h000010),
    .OFFSET2(22'h000020), .OFFSET3(22'h3FFFF0)
  ) u_fp (
    .CLK(CLK), .RESET_N(RESET_N), .REQ_CS(REQ_CS),
    .REQ_ADDR0(REQ_ADDR0), .REQ_ADDR1(REQ_ADDR1), .REQ_ADDR2(REQ_ADDR2), .REQ_ADDR3(REQ_ADDR3),
    .REQ_OK(fp_ok),
    .REQ_DOUT0(fp_dout0), .REQ_DOUT1(fp_dout1), .REQ_DOUT2(fp_dout2), .REQ_DOUT3(fp_dout3),
    .BA_ADDR(fp_ba_addr), .BA_RD(fp_ba_rd), .BA_ACK(BA_ACK), .BA_DST(BA_DST),
    .BA_DOK(BA_DOK), .BA_RDY(BA_RDY), .DATA_READ(DATA_READ),
    .BUSY(fp_busy), .dbg_state(fp_dbg_state)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // A burst that ends after fewer than two data beats is a board fault.
  always @(posedge CLK) begin
    if (!RESET_N) begin
      beat_mon = 0;
    end else if (dbg_state == 2'd2) begin
      if (BA_DOK) beat_mon++;
      if (BA_RDY) begin
        total++;
        assert (beat_mon >= 2) else begin
          bad++;
          $error("FAIL short_burst observed=%0d beats expected=2", beat_mon);
        end
      end
    end else begin
      beat_mon = 0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rd(input string tag);
    int n;
    n = 0;
    while (!BA_RD && n < 20) begin
      tick();
      n++;
    end
    check(tag, 64'(BA_RD), 64'd1);
  endtask

  // Entered just after the grant edge; returns just after the edge into DONE.
  task automatic serve(input int delay, input logic [15:0] lo, input logic [15:0] hi,
                       input logic [21:0] exp_addr, input string tag);
    check({tag, "_req"}, 64'({BA_RD, BUSY, BA_ADDR}), 64'({1'b1, 1'b1, exp_addr}));
    for (int d = 0; d < delay; d++) begin
      tick();
      check({tag, "_stall"}, 64'({BA_RD, BUSY, BA_ADDR}), 64'({1'b1, 1'b1, exp_addr}));
    end
    BA_ACK = 1'b1;
    tick();
    BA_ACK = 1'b0;
    check({tag, "_acked"}, 64'({BA_RD, BUSY}), 64'({1'b0, 1'b1}));
    BA_DOK = 1'b1; BA_DST = 1'b1; DATA_READ = lo;
    tick();
    BA_DST = 1'b0; DATA_READ = hi; BA_RDY = 1'b1;
    tick();
    BA_DOK = 1'b0; BA_RDY = 1'b0;
  endtask

  logic [21:0] exp_rr [4];
  logic [21:0] exp_fp [4];

  initial begin
    RESET_N = 1'b0; REQ_CS = 4'd0;
    REQ_ADDR0 = 22'd0; REQ_ADDR1 = 22'd0; REQ_ADDR2 = 22'd0; REQ_ADDR3 = 22'd0;
    BA_ACK = 1'b0; BA_DST = 1'b0; BA_DOK = 1'b0; BA_RDY = 1'b0; DATA_READ = 16'd0;
    exp_rr = '{22'h000410, 22'h000520, 22'h0005F0, 22'h200300};
    exp_fp = '{22'h200300, 22'h000410, 22'h000520, 22'h0005F0};

    // Reset state
    #1;
    check("rst_ba", 64'({BA_RD, BUSY, BA_ADDR}), 64'd0);
    check("rst_ok", 64'(REQ_OK), 64'd0);
    check("rst_dout0", 64'(REQ_DOUT0), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    tick(); tick();
    RESET_N = 1'b1;
    tick();

    // 1: single miss with offset, immediate ACK, back-to-back beats
    REQ_ADDR0 = 22'h000100; REQ_CS = 4'b0001;
    #1;
    check("t1_ok_miss", 64'(REQ_OK), 64'd0);
    wait_rd("t1_rd");
    serve(0, 16'h1234, 16'hABCD, 22'h200100, "t1");
    check("t1_ok_done", 64'(REQ_OK), 64'd0);
    tick();
    check("t1_ok", 64'(REQ_OK), 64'b0001);
    check("t1_dout0", 64'(REQ_DOUT0), 64'hABCD1234);
    check("t1_busy", 64'(BUSY), 64'd0);

    // 2: repeat hit completes in the same cycle without SDRAM traffic
    REQ_CS = 4'b0000;
    tick();
    REQ_CS = 4'b0001;
    #1;
    check("t2_ok_same", 64'(REQ_OK), 64'b0001);
    tick();
    check("t2_no_rd", 64'({BA_RD, BUSY}), 64'd0);
    REQ_CS = 4'b0000;
    tick();

    // 3: four simultaneous misses; RR order 1,2,3,0 and fixed order 0,1,2,3
    REQ_ADDR0 = 22'h000300; REQ_ADDR1 = 22'h000400;
    REQ_ADDR2 = 22'h000500; REQ_ADDR3 = 22'h000600;
    REQ_CS = 4'b1111;
    #1;
    check("t3_ok_none", 64'(REQ_OK), 64'd0);
    for (int k = 0; k < 4; k++) begin
      wait_rd("t3_rd");
      check("t3_fp_addr", 64'(fp_ba_addr), 64'(exp_fp[k]));
      serve(0, 16'h1000 + 16'(k), 16'h2000 + 16'(k), exp_rr[k], "t3_rr");
    end
    tick();
    check("t3_ok_all", 64'(REQ_OK), 64'b1111);
    check("t3_fp_ok_all", 64'(fp_ok), 64'b1111);
    check("t3_dout1", 64'(REQ_DOUT1), 64'h20001000);
    check("t3_dout2", 64'(REQ_DOUT2), 64'h20011001);
    check("t3_dout3", 64'(REQ_DOUT3), 64'h20021002);
    check("t3_dout0", 64'(REQ_DOUT0), 64'h20031003);
    check("t3_fp_dout0", 64'(fp_dout0), 64'h20001000);
    check("t3_fp_dout3", 64'(fp_dout3), 64'h20031003);
    REQ_CS = 4'b0000;
    tick();

    // 4: address changes mid-burst; cache takes the latched address, then refetches
    REQ_ADDR0 = 22'h000100; REQ_CS = 4'b0001;
    wait_rd("t4_rd");
    check("t4_addr", 64'(BA_ADDR), 64'h200100);
    BA_ACK = 1'b1;
    tick();
    BA_ACK = 1'b0;
    BA_DOK = 1'b1; DATA_READ = 16'h5555;
    tick();
    REQ_ADDR0 = 22'h000200;
    DATA_READ = 16'h6666; BA_RDY = 1'b1;
    tick();
    BA_DOK = 1'b0; BA_RDY = 1'b0;
    check("t4_ok_done", 64'(REQ_OK), 64'd0);
    tick();
    check("t4_ok_new", 64'(REQ_OK), 64'd0);
    check("t4_dout0", 64'(REQ_DOUT0), 64'h66665555);
    REQ_ADDR0 = 22'h000100;
    #1;
    check("t4_tag_old", 64'(REQ_OK), 64'b0001);
    REQ_ADDR0 = 22'h000200;
    #1;
    check("t4_ok_back", 64'(REQ_OK), 64'd0);
    tick();
    check("t4_refetch", 64'({BA_RD, BA_ADDR}), 64'({1'b1, 22'h200200}));
    serve(0, 16'h7777, 16'h8888, 22'h200200, "t4b");
    tick();
    check("t4_ok_final", 64'(REQ_OK), 64'b0001);
    check("t4_dout0_final", 64'(REQ_DOUT0), 64'h88887777);
    REQ_CS = 4'b0000;
    tick();

    // 5: reset after one beat abandons the burst; trailing beats are ignored
    REQ_ADDR0 = 22'h000400; REQ_CS = 4'b0001;
    wait_rd("t5_rd");
    BA_ACK = 1'b1;
    tick();
    BA_ACK = 1'b0;
    BA_DOK = 1'b1; DATA_READ = 16'h9999;
    tick();
    BA_DOK = 1'b0;
    RESET_N = 1'b0;
    #1;
    check("t5_rst_ba", 64'({BA_RD, BUSY}), 64'd0);
    check("t5_rst_ok", 64'(REQ_OK), 64'd0);
    check("t5_rst_dout0", 64'(REQ_DOUT0), 64'd0);
    REQ_CS = 4'b0000;
    tick();
    RESET_N = 1'b1;
    BA_DOK = 1'b1; BA_RDY = 1'b1; DATA_READ = 16'hEEEE;
    tick(); tick();
    BA_DOK = 1'b0; BA_RDY = 1'b0;
    check("t5_trail_dout0", 64'(REQ_DOUT0), 64'd0);
    check("t5_trail_ba", 64'({BA_RD, BUSY}), 64'd0);
    check("t5_trail_state", 64'(dbg_state), 64'd0);
    tick();

    // 6: ACK delayed seven cycles; request held stable and BUSY stays high
    REQ_ADDR1 = 22'h000800; REQ_CS = 4'b0010;
    wait_rd("t6_rd");
    serve(7, 16'h4321, 16'h8765, 22'h000810, "t6");
    tick();
    check("t6_ok", 64'(REQ_OK), 64'b0010);
    check("t6_dout1", 64'(REQ_DOUT1), 64'h87654321);
    REQ_CS = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
